// File: rtl/ipselector_cpu_debug_master_shifter.sv
// ipselector_cpu_debug_master_shifter
// System-clock debug initiator driving the Nios II debug slave's
// virtual-JTAG style interface. Each command loads an IR, shifts a DR
// LSB first while capturing tdo, and returns the captured word.
// Optional feature macro: DBG_IR_CACHE_EN (skip update-IR when the new
// instruction matches the last one loaded).
module ipselector_cpu_debug_master_shifter #(
  parameter int DR_WIDTH  = 38,
  parameter int IR_WIDTH  = 2,
  parameter int TCK_DIV   = 4,
  parameter int RTI_TICKS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_e1dr,
  output logic                jtag_state_rti,
  output logic                tdi,
  input  logic                tdo
);

  localparam int TICK_W  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int CNT_MAX = (DR_WIDTH > RTI_TICKS) ? DR_WIDTH : RTI_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_E1DR,
    ST_RTI,
    ST_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DR_WIDTH-1:0] sr;
  logic                tick;
  logic                accept;
  logic                skip_uir;
  logic                sdr_last;
  logic                rti_last;

  assign tick     = (tick_cnt == TICK_W'(TCK_DIV - 1));
  assign accept   = cmd_valid && (state == ST_IDLE);
  assign sdr_last = tick && (bit_cnt == CNT_W'(DR_WIDTH - 1));
  assign rti_last = tick && (bit_cnt == CNT_W'(RTI_TICKS - 1));

`ifdef DBG_IR_CACHE_EN
  logic [IR_WIDTH-1:0] last_ir;
  logic                last_ir_vld;

  assign skip_uir = last_ir_vld && (cmd_ir == last_ir);

  // Remember the instruction most recently committed by an update-IR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ir     <= '0;
      last_ir_vld <= 1'b0;
    end else if (state == ST_UIR && tick) begin
      last_ir     <= ir_in;
      last_ir_vld <= 1'b1;
    end
  end
`else
  assign skip_uir = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: every scan state lasts whole ticks, RESP waits for the consumer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = skip_uir ? ST_CDR : ST_UIR;
      ST_UIR:  if (tick)      state_nxt = ST_CDR;
      ST_CDR:  if (tick)      state_nxt = ST_SDR;
      ST_SDR:  if (sdr_last)  state_nxt = ST_E1DR;
      ST_E1DR: if (tick)      state_nxt = ST_RTI;
      ST_RTI:  if (rti_last)  state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; strobes are held for the whole state duration
  always_comb begin
    cmd_ready      = (state == ST_IDLE);
    busy           = (state != ST_IDLE);
    rsp_valid      = (state == ST_RESP);
    vs_uir         = (state == ST_UIR);
    vs_cdr         = (state == ST_CDR);
    vs_sdr         = (state == ST_SDR);
    vs_e1dr        = (state == ST_E1DR);
    jtag_state_rti = (state == ST_IDLE) || (state == ST_RTI) || (state == ST_RESP);
    tdi            = (state == ST_SDR) && sr[0];
  end

  // Tick divider: free-runs during a scan, parked at zero in IDLE and RESP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (accept || state == ST_IDLE || state == ST_RESP || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Shared counter: DR bits in SDR, idle ticks in RTI; cleared in the state before each
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else if (state == ST_CDR || state == ST_E1DR) begin
      bit_cnt <= '0;
    end else if (tick && (state == ST_SDR || state == ST_RTI)) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Command capture, DR shifting with tdo sampled on SDR ticks, response latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr       <= '0;
      ir_in    <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        sr <= cmd_data;
        if (!skip_uir) begin
          ir_in <= cmd_ir;
        end
      end else if (state == ST_SDR && tick) begin
        sr <= {tdo, sr[DR_WIDTH-1:1]};
      end
      if (state == ST_RTI && rti_last) begin
        rsp_data <= sr;
      end
    end
  end

endmodule

// File: tb/tb_ipselector_cpu_debug_master_shifter.sv
// Testbench for ipselector_cpu_debug_master_shifter.
// Table-driven vectors, hand-written corner sequences and random commands,
// with expectations taken from the scan rules (tdo bit k is taken on the
// last clock of the k-th SDR bit window). Honours DBG_IR_CACHE_EN.
module tb_ipselector_cpu_debug_master_shifter;

  localparam int DRW      = 38;
  localparam int TCK      = 4;
  localparam int LAT_FULL = 173;
  localparam int LAT_HIT  = 169;
  localparam int SDR_CYC  = 152;

  typedef struct {
    logic [1:0]     ir;
    logic [DRW-1:0] data;
    logic [DRW-1:0] pattern;
    bit             loop;
    int             hold;
    bit             early;
    bit             spam;
    logic [DRW-1:0] exp_rsp;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_ir;
  logic [DRW-1:0] cmd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DRW-1:0] rsp_data;
  logic           busy;
  logic [1:0]     ir_in;
  logic           vs_uir;
  logic           vs_cdr;
  logic           vs_sdr;
  logic           vs_e1dr;
  logic           jtag_state_rti;
  logic           tdi;
  logic           tdo = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [DRW-1:0] cur_data = '0;
  logic [DRW-1:0] cur_pattern = '0;
  bit             cur_loop = 1'b0;

  int sdr_cnt = 0;
  int sdr_len = 0;
  int uir_cycles = 0;
  int tdi_bad = 0;
  int excl_bad = 0;
  int mon_k = 0;

  bit         model_vld = 1'b0;
  logic [1:0] model_ir = '0;

  ipselector_cpu_debug_master_shifter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .ir_in          (ir_in),
    .vs_uir         (vs_uir),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_e1dr        (vs_e1dr),
    .jtag_state_rti (jtag_state_rti),
    .tdi            (tdi),
    .tdo            (tdo)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Slave model: drives tdo, watches tdi and strobe exclusivity each cycle
  always @(negedge clk) begin
    if (!reset_n || !busy) begin
      sdr_cnt    = 0;
      sdr_len    = 0;
      uir_cycles = 0;
      tdi_bad    = 0;
    end
    if ((int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_e1dr)) > 1 ||
        ((vs_uir || vs_cdr || vs_sdr || vs_e1dr) && jtag_state_rti))
      excl_bad++;
    if (vs_uir)
      uir_cycles++;
    if (vs_sdr) begin
      mon_k = sdr_cnt / TCK;
      if (mon_k >= DRW) begin
        tdi_bad++;
        tdo = $urandom_range(0, 1);
      end else begin
        if (tdi !== cur_data[mon_k])
          tdi_bad++;
        if (cur_loop)
          tdo = tdi;
        else if ((sdr_cnt % TCK) == TCK - 1)
          tdo = cur_pattern[mon_k];
        else
          tdo = $urandom_range(0, 1);
      end
      sdr_cnt++;
      sdr_len = sdr_cnt;
    end else begin
      tdo = $urandom_range(0, 1);
    end
  end

  // Compare one observed value with its expected value
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Run one full command/response transaction and check it
  task automatic applyStimulus(input logic [1:0] ir, input logic [DRW-1:0] data,
                               input logic [DRW-1:0] pattern, input bit loop,
                               input int hold, input bit early, input bit spam,
                               input logic [DRW-1:0] exp_rsp, input string tag);
    bit             hit;
    int             n;
    int             unstable;
    logic [DRW-1:0] held;
    hit = 1'b0;
`ifdef DBG_IR_CACHE_EN
    hit = model_vld && (ir == model_ir);
`endif
    cur_data    = data;
    cur_pattern = pattern;
    cur_loop    = loop;
    @(negedge clk);
    cmd_ir    = ir;
    cmd_data  = data;
    cmd_valid = 1'b1;
    rsp_ready = early;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput({tag, ".ready_drop"}, 64'(cmd_ready), 64'(0));
    if (spam) begin
      cmd_ir   = ~ir;
      cmd_data = ~data;
    end else begin
      cmd_valid = 1'b0;
    end
    n = 1;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".latency"}, 64'(n), 64'(hit ? LAT_HIT : LAT_FULL));
    checkOutput({tag, ".rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
    checkOutput({tag, ".ir_in"}, 64'(ir_in), 64'(ir));
    checkOutput({tag, ".sdr_cycles"}, 64'(sdr_len), 64'(SDR_CYC));
    checkOutput({tag, ".uir_cycles"}, 64'(uir_cycles), 64'(hit ? 0 : TCK));
    checkOutput({tag, ".tdi_bits"}, 64'(tdi_bad), 64'(0));
    model_vld = 1'b1;
    model_ir  = ir;
    held      = rsp_data;
    unstable  = 0;
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        if (rsp_data !== held || rsp_valid !== 1'b1 || cmd_ready !== 1'b0)
          unstable++;
      end
      if (hold > 0)
        checkOutput({tag, ".backpressure_hold"}, 64'(unstable), 64'(0));
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, ".post_idle"}, {61'd0, rsp_valid, cmd_ready, busy}, 64'b010);
  endtask

  vec_t vecs[5];

  initial begin
    logic [63:0]    r;
    logic [DRW-1:0] rd;
    logic [DRW-1:0] rp;
    bit             rl;
    int             quiet;

    vecs[0] = '{2'b01, 38'h15_A5A5_A5A5, 38'h0, 1'b1, 0, 1'b0, 1'b0, 38'h15_A5A5_A5A5};
    vecs[1] = '{2'b11, 38'h0, 38'h2A_0F0F_3C3C, 1'b0, 0, 1'b0, 1'b0, 38'h2A_0F0F_3C3C};
    vecs[2] = '{2'b00, 38'h3F_FFFF_FFFF, 38'h00_0000_0001, 1'b0, 20, 1'b0, 1'b1, 38'h00_0000_0001};
    vecs[3] = '{2'b10, 38'h12_3456_789A, 38'h20_0000_0000, 1'b0, 0, 1'b1, 1'b0, 38'h20_0000_0000};
    vecs[4] = '{2'b10, 38'h2A_AAAA_AAAA, 38'h0, 1'b1, 3, 1'b0, 1'b0, 38'h2A_AAAA_AAAA};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_ir    = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.during", {56'd0, cmd_ready, busy, rsp_valid, jtag_state_rti, vs_uir, vs_cdr, vs_sdr, vs_e1dr}, 64'b1001_0000);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset.flags", {56'd0, cmd_ready, busy, rsp_valid, jtag_state_rti, vs_uir, vs_cdr, vs_sdr, vs_e1dr}, 64'b1001_0000);
    checkOutput("reset.tdi_ir", {61'd0, tdi, ir_in}, 64'd0);
    checkOutput("reset.rsp_data", 64'(rsp_data), 64'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i].ir, vecs[i].data, vecs[i].pattern, vecs[i].loop, vecs[i].hold,
                    vecs[i].early, vecs[i].spam, vecs[i].exp_rsp, $sformatf("vec%0d", i));

    $display("[TB] reset mid-scan");
    @(negedge clk);
    cur_data    = 38'h0C_3355_AA01;
    cur_loop    = 1'b1;
    cmd_ir      = 2'b01;
    cmd_data    = cur_data;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (59) @(negedge clk);
    checkOutput("midreset.in_sdr", {62'd0, busy, vs_sdr}, 64'b11);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset.flags", {56'd0, cmd_ready, busy, rsp_valid, jtag_state_rti, vs_uir, vs_cdr, vs_sdr, vs_e1dr}, 64'b1001_0000);
    checkOutput("midreset.data", {rsp_data, tdi, ir_in}, 64'd0);
    model_vld = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    quiet = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid || busy)
        quiet++;
    end
    checkOutput("midreset.no_rsp", 64'(quiet), 64'd0);
    applyStimulus(2'b01, 38'h0C_3355_AA01, 38'h0, 1'b1, 0, 1'b0, 1'b0, 38'h0C_3355_AA01, "after_reset");

    $display("[TB] back-to-back same IR");
    applyStimulus(2'b10, 38'h01_0203_0405, 38'h3E_DCBA_9876, 1'b0, 0, 1'b0, 1'b0, 38'h3E_DCBA_9876, "ircache_a");
    applyStimulus(2'b10, 38'h33_0000_FFFF, 38'h0, 1'b1, 0, 1'b0, 1'b0, 38'h33_0000_FFFF, "ircache_b");

    $display("[TB] random commands");
    for (int i = 0; i < 16; i++) begin
      r  = {$urandom(), $urandom()};
      rd = r[DRW-1:0];
      r  = {$urandom(), $urandom()};
      rp = r[DRW-1:0];
      rl = 1'($urandom_range(0, 1));
      applyStimulus(2'($urandom_range(0, 3)), rd, rp, rl, $urandom_range(0, 5),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rl ? rd : rp, $sformatf("rand%0d", i));
    end

    checkOutput("strobe_exclusive", 64'(excl_bad), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
